alu_pipe: RTL and testbench

- Parametrised, two-stage pipelined successor to the combinational datapath ALU.
- Same op encoding for AND/OR/ADD/LSR/LSL/SUB/PASSB; adds ASR and XOR, a full NZCV flag set, and a valid/ready handshake on both sides.
- Sits between register-file read and write-back, and tolerates write-back stalls without losing operations.

---
 rtl/alu_pipe.sv | 152 +++++++++++++++
 tb/tb_alu_pipe.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe -- two-stage pipelined ALU with valid/ready handshakes.
//
// Stage 1 captures the operands and the op code. Stage 2 captures the result
// and the NZCV flags and drives every output directly from flops, so there is
// no combinational path from BusA/BusB/ALUCtrl to the outputs. A stalled
// consumer (out_ready=0) holds stage 2. Stage 1 keeps accepting until it is
// also full, so no operation is ever dropped or duplicated.
//
// Ports
//   Clk        rising-edge clock
//   Reset_L    asynchronous reset, active low; flushes both stages
//   BusA       operand A                       [WIDTH-1:0]
//   BusB       operand B / shift amount source [WIDTH-1:0]
//   ALUCtrl    operation select                [3:0]
//   in_valid   producer offers an op
//   in_ready   block accepts an op this cycle (depends on out_ready)
//   BusW       result                          [WIDTH-1:0]
//   Zero       BusW == 0
//   Neg        BusW[WIDTH-1]
//   Carry      ADD carry-out / SUB not-borrow, else 0
//   Ovf        ADD/SUB signed overflow, else 0
//   out_valid  BusW and flags hold a result
//   out_ready  consumer takes the result this cycle
// ---------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset_L,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic [3:0]       ALUCtrl,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero,
  output logic             Neg,
  output logic             Carry,
  output logic             Ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [3:0] {
    OP_AND   = 4'd0,
    OP_OR    = 4'd1,
    OP_ADD   = 4'd2,
    OP_LSR   = 4'd3,
    OP_LSL   = 4'd4,
    OP_ASR   = 4'd5,
    OP_SUB   = 4'd6,
    OP_PASSB = 4'd7,
    OP_XOR   = 4'd8
  } aluOp_e;

  // Pipeline control
  logic             s1_valid, s2_valid;
  logic             s1_adv, s2_adv;

  // Stage 1 operand registers
  logic [WIDTH-1:0] s1A, s1B;
  logic [3:0]       s1Op;

  // Stage 1 -> stage 2 combinational result
  logic [WIDTH-1:0] result;
  logic             carryNext, ovfNext;
  logic [WIDTH:0]   sumW, diffW;
  logic [SHAMT_W-1:0] shamt;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = !s1_valid || s2_adv;
  assign out_valid = s2_valid;

  // Stage 1 valid bit.
  // NOTE: state registers use non-blocking assignment so every flop samples
  // values from before the edge, regardless of block evaluation order.
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L)      s1_valid <= 1'b0;
    else if (in_ready) s1_valid <= in_valid;
  end

  // NOTE: stage 1 data registers have no reset; their contents are ignored
  // until s1_valid is set, which costs nothing and keeps reset fan-out small.
  always_ff @(posedge Clk) begin
    if (in_valid && in_ready) begin
      s1A  <= BusA;
      s1B  <= BusB;
      s1Op <= ALUCtrl;
    end
  end

  // Subtraction is A + ~B + 1, so the top bit is the not-borrow (A >= B).
  assign sumW  = {1'b0, s1A} + {1'b0, s1B};
  assign diffW = {1'b0, s1A} + {1'b0, ~s1B} + {{WIDTH{1'b0}}, 1'b1};
  assign shamt = s1B[SHAMT_W-1:0];

  // NOTE: every output of this block gets a default first, so no path through
  // the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    result    = '0;
    carryNext = 1'b0;
    ovfNext   = 1'b0;
    case (s1Op)
      OP_AND:   result = s1A & s1B;
      OP_OR:    result = s1A | s1B;
      OP_ADD: begin
        result    = sumW[WIDTH-1:0];
        carryNext = sumW[WIDTH];
        ovfNext   = (s1A[WIDTH-1] == s1B[WIDTH-1]) &&
                    (result[WIDTH-1] != s1A[WIDTH-1]);
      end
      OP_LSR:   result = s1A >> shamt;
      OP_LSL:   result = s1A << shamt;
      OP_ASR:   result = $unsigned($signed(s1A) >>> shamt);
      OP_SUB: begin
        result    = diffW[WIDTH-1:0];
        carryNext = diffW[WIDTH];
        ovfNext   = (s1A[WIDTH-1] != s1B[WIDTH-1]) &&
                    (result[WIDTH-1] != s1A[WIDTH-1]);
      end
      OP_PASSB: result = s1B;
      OP_XOR:   result = s1A ^ s1B;
      default:  result = '0;  // unassigned codes 9..15
    endcase
  end

  // Stage 2: result and flags. Holds while the consumer stalls; valid drops
  // when the stage drains and stage 1 has nothing to hand over.
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      s2_valid <= 1'b0;
      BusW     <= '0;
      Zero     <= 1'b0;
      Neg      <= 1'b0;
      Carry    <= 1'b0;
      Ovf      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_adv) begin
        BusW  <= result;
        Zero  <= (result == '0);
        Neg   <= result[WIDTH-1];
        Carry <= carryNext;
        Ovf   <= ovfNext;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe -- directed self-checking bench for alu_pipe (WIDTH = 64).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Flags are compared as a packed {Neg, Zero, Carry, Ovf} nibble.
// ---------------------------------------------------------------------------
module tb_alu_pipe;

  localparam int W = 64;

  localparam logic [3:0] AND_OP   = 4'd0;
  localparam logic [3:0] OR_OP    = 4'd1;
  localparam logic [3:0] ADD_OP   = 4'd2;
  localparam logic [3:0] LSR_OP   = 4'd3;
  localparam logic [3:0] LSL_OP   = 4'd4;
  localparam logic [3:0] ASR_OP   = 4'd5;
  localparam logic [3:0] SUB_OP   = 4'd6;
  localparam logic [3:0] PASSB_OP = 4'd7;
  localparam logic [3:0] XOR_OP   = 4'd8;

  logic         Clk;
  logic         Reset_L;
  logic [W-1:0] BusA, BusB;
  logic [3:0]   ALUCtrl;
  logic         in_valid, in_ready;
  logic [W-1:0] BusW;
  logic         Zero, Neg, Carry, Ovf;
  logic         out_valid, out_ready;

  int checks = 0;
  int passed = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Reset_L   (Reset_L),
    .BusA      (BusA),
    .BusB      (BusB),
    .ALUCtrl   (ALUCtrl),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .BusW      (BusW),
    .Zero      (Zero),
    .Neg       (Neg),
    .Carry     (Carry),
    .Ovf       (Ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    ALUCtrl  = op;
    BusA     = a;
    BusB     = b;
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] w, input logic [3:0] nzcv);
    chk({tag, ".valid"}, W'(out_valid), W'(1'b1));
    chk({tag, ".BusW"},  BusW, w);
    chk({tag, ".NZCV"},  W'({Neg, Zero, Carry, Ovf}), W'(nzcv));
  endtask

  initial begin
    Reset_L   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ALUCtrl   = '0;
    BusA      = '0;
    BusB      = '0;

    // ---- Reset state -------------------------------------------------------
    repeat (3) cyc();
    chk("rst.out_valid", W'(out_valid), W'(1'b0));
    chk("rst.BusW",      BusW, '0);
    chk("rst.NZCV",      W'({Neg, Zero, Carry, Ovf}), W'(4'b0000));
    chk("rst.in_ready",  W'(in_ready), W'(1'b1));
    Reset_L = 1'b1;
    cyc();

    // ---- Single op, 2-cycle latency -----------------------------------------
    drive(ADD_OP, 64'h1234, 64'hABCD_0000);
    cyc();                                   // accepted (cycle t)
    in_valid = 1'b0;
    chk("lat.t+1.out_valid", W'(out_valid), W'(1'b0));
    cyc();                                   // t+2
    expect_out("lat.add", 64'hABCD_1234, 4'b0000);
    out_ready = 1'b1;
    cyc();                                   // t+3, result consumed
    chk("lat.t+3.out_valid", W'(out_valid), W'(1'b0));

    // ---- Back-to-back stream ------------------------------------------------
    drive(SUB_OP, 64'h7DA, 64'h7DA);          cyc();
    drive(SUB_OP, 64'h9, 64'h2);              cyc();
    expect_out("b2b.sub0", 64'h0, 4'b0110);
    drive(LSL_OP, 64'hAB7, 64'd3);            cyc();
    expect_out("b2b.sub7", 64'h7, 4'b0010);
    drive(LSR_OP, 64'hABC, 64'd5);            cyc();
    expect_out("b2b.lsl", 64'h55B8, 4'b0000);
    drive(ASR_OP, 64'h8000_0000_0000_0000, 64'd4); cyc();
    expect_out("b2b.lsr", 64'h55, 4'b0000);
    in_valid = 1'b0;                          cyc();
    expect_out("b2b.asr", 64'hF800_0000_0000_0000, 4'b1000);
    cyc();
    chk("b2b.drained", W'(out_valid), W'(1'b0));

    // ---- Flag boundaries ----------------------------------------------------
    drive(ADD_OP, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1); cyc();
    drive(ADD_OP, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1); cyc();
    expect_out("bnd.add_wrap", 64'h0, 4'b0110);
    drive(SUB_OP, 64'h2, 64'h4);                   cyc();
    expect_out("bnd.add_ovf", 64'h8000_0000_0000_0000, 4'b1001);
    in_valid = 1'b0;                               cyc();
    expect_out("bnd.sub_borrow", 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);
    cyc();

    // ---- Backpressure -------------------------------------------------------
    out_ready = 1'b0;
    drive(XOR_OP, 64'hF0, 64'hFF);   cyc();
    drive(OR_OP, 64'h2FF, 64'hAB9);  cyc();
    drive(AND_OP, 64'hBB, 64'h4A7);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp.stall%0d.in_ready", i), W'(in_ready), W'(1'b0));
      expect_out($sformatf("bp.stall%0d", i), 64'h0F, 4'b0000);
      if (i < 4) cyc();
    end
    out_ready = 1'b1;
    cyc();                            // XOR consumed, AND accepted
    expect_out("bp.or", 64'hAFF, 4'b0000);
    drive(PASSB_OP, 64'hDEAD, 64'h62A); cyc();
    expect_out("bp.and", 64'hA3, 4'b0000);
    in_valid = 1'b0;                  cyc();
    expect_out("bp.passb", 64'h62A, 4'b0000);
    cyc();
    chk("bp.drained", W'(out_valid), W'(1'b0));

    // ---- Shift masking, zero shift, illegal op ------------------------------
    drive(LSL_OP, 64'h2, 64'h47);                   cyc();
    drive(ASR_OP, 64'h8000_0000_0000_0001, 64'h40); cyc();
    expect_out("sh.lsl_mask", 64'h100, 4'b0000);
    drive(4'hC, 64'h5, 64'h5);                      cyc();
    expect_out("sh.asr_zero", 64'h8000_0000_0000_0001, 4'b1000);
    in_valid = 1'b0;                                cyc();
    expect_out("illegal.C", 64'h0, 4'b0100);
    cyc();

    // ---- Mid-operation asynchronous reset -----------------------------------
    drive(ADD_OP, 64'h10, 64'h20); cyc();
    drive(OR_OP, 64'h100, 64'h1);  cyc();   // ADD in stage 2, OR in stage 1
    #2;
    Reset_L  = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mrst.out_valid", W'(out_valid), W'(1'b0));
    chk("mrst.BusW",      BusW, '0);
    chk("mrst.NZCV",      W'({Neg, Zero, Carry, Ovf}), W'(4'b0000));
    chk("mrst.in_ready",  W'(in_ready), W'(1'b1));
    #1;
    Reset_L = 1'b1;
    cyc();
    chk("mrst.flushed", W'(out_valid), W'(1'b0));
    drive(ADD_OP, 64'h3, 64'h4);   cyc();
    in_valid = 1'b0;
    chk("mrst.t+1", W'(out_valid), W'(1'b0));
    cyc();
    expect_out("mrst.add", 64'h7, 4'b0000);
    cyc();
    chk("mrst.end", W'(out_valid), W'(1'b0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
